// File: rtl/serv_alu_pkg.sv
// Shared encodings, state type and beat-counter sizing for serv_alu_wide.
// Optional shift datapath is selected with SERV_ALU_SHIFT_EN (see serv_alu_wide).
package serv_alu_pkg;

    localparam logic [2:0] ALU_RESULT_ADD = 3'd0;
    localparam logic [2:0] ALU_RESULT_SR  = 3'd1;
    localparam logic [2:0] ALU_RESULT_LT  = 3'd2;
    localparam logic [2:0] ALU_RESULT_XOR = 3'd3;
    localparam logic [2:0] ALU_RESULT_OR  = 3'd4;
    localparam logic [2:0] ALU_RESULT_AND = 3'd5;

    localparam logic ALU_CMP_EQ = 1'b0;
    localparam logic ALU_CMP_LT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OUT  = 2'd2
    } alu_state_e;

    // Width of the beat counter; never narrower than one bit.
    function automatic int beat_cnt_w(input int xlen, input int w);
        int n;
        n = xlen / w;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serv_alu_slice_add.sv
// W-bit adder slice with a registered carry between beats.
// Carry-in comes from i_cin on the first beat, from the stored carry afterwards.
module serv_alu_slice_add
    import serv_alu_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_first,
    input  logic         i_cin,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic         r_carry;
    logic         w_cin;
    logic [W:0]   w_full;

    assign w_cin  = i_first ? i_cin : r_carry;
    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, w_cin};
    assign o_sum  = w_full[W-1:0];
    assign o_cout = w_full[W];

    always_ff @(posedge clk) begin
        if (i_rst || i_clr) begin
            r_carry <= 1'b0;
        end else if (i_en) begin
            r_carry <= w_full[W];
        end
    end

endmodule

// File: rtl/serv_alu_wide.sv
// Multi-bit-per-beat serv ALU: W bits per beat, LSB first, XLEN/W beats per phase.
// Define SERV_ALU_SHIFT_EN to build the shift register and the SR output phase.
//
// state | meaning
// IDLE  | waiting for i_start; controls latched on acceptance
// LOAD  | operands consumed each beat; ADD/XOR/OR/AND stream out here
// OUT   | SR/LT result word emitted from captured state
module serv_alu_wide
    import serv_alu_pkg::*;
#(
    parameter int W    = 1,
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [2:0]   i_rd_sel,
    input  logic         i_sub,
    input  logic         i_cmp_sel,
    input  logic         i_cmp_neg,
    input  logic         i_cmp_uns,
    input  logic         i_sh_right,
    input  logic         i_sh_signed,
    input  logic [W-1:0] i_rs1,
    input  logic [W-1:0] i_op_b,
    output logic [W-1:0] o_rd,
    output logic         o_rd_valid,
    output logic         o_cmp,
    output logic         o_busy,
    output logic         o_done
);

    localparam int NB = XLEN / W;
    localparam int CW = beat_cnt_w(XLEN, W);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_OUT  = ST_OUT;
`ifdef SERV_ALU_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_rd_sel;
    logic          r_sub, r_cmp_sel, r_cmp_neg, r_cmp_uns, r_two_phase;
    logic          r_eq, r_lt;

    logic          w_start, w_load, w_out, w_first, w_last;
    logic [W-1:0]  w_add_sum, w_cmp_sum_unused, w_sh_slice, w_lt_slice;
    logic          w_add_cout_unused, w_cmp_cout;
    logic          w_eq_now, w_lt_now, w_eq, w_lt;

    assign w_start = (r_state == S_IDLE) & i_start;
    assign w_load  = (r_state == S_LOAD);
    assign w_out   = (r_state == S_OUT);
    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == CW'(NB - 1));

    serv_alu_slice_add #(.W(W)) u_add (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_clr   (w_start),
        .i_en    (w_load),
        .i_first (w_first),
        .i_cin   (r_sub),
        .i_a     (i_rs1),
        .i_b     (r_sub ? ~i_op_b : i_op_b),
        .o_sum   (w_add_sum),
        .o_cout  (w_add_cout_unused)
    );

    // Compare chain always subtracts, independent of the result adder.
    serv_alu_slice_add #(.W(W)) u_cmp (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_clr   (w_start),
        .i_en    (w_load),
        .i_first (w_first),
        .i_cin   (1'b1),
        .i_a     (i_rs1),
        .i_b     (~i_op_b),
        .o_sum   (w_cmp_sum_unused),
        .o_cout  (w_cmp_cout)
    );

    assign w_eq_now = (w_first ? 1'b1 : r_eq) & (i_rs1 == i_op_b);
    assign w_lt_now = (!r_cmp_uns && (i_rs1[W-1] != i_op_b[W-1])) ? i_rs1[W-1] : ~w_cmp_cout;
    assign w_eq     = w_load ? w_eq_now : r_eq;
    assign w_lt     = w_load ? w_lt_now : r_lt;

`ifdef SERV_ALU_SHIFT_EN
    localparam int IW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES = '1;
    logic [XLEN-1:0] r_sh;
    logic [4:0]      r_shamt, w_shamt_nxt;
    logic            r_sh_right, r_sh_signed, w_fill;
    logic [XLEN-1:0] w_sh_word;

    always_comb begin
        w_shamt_nxt = r_shamt;
        for (int i = 0; i < W; i++) begin
            if (int'(r_cnt) * W + i < 5) w_shamt_nxt[3'(int'(r_cnt) * W + i)] = i_op_b[i];
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_sh        <= '0;
            r_shamt     <= '0;
            r_sh_right  <= 1'b0;
            r_sh_signed <= 1'b0;
        end else if (w_start) begin
            r_sh_right  <= i_sh_right;
            r_sh_signed <= i_sh_signed;
        end else if (w_load) begin
            r_sh    <= {i_rs1, r_sh[XLEN-1:W]};
            r_shamt <= w_shamt_nxt;
        end
    end

    assign w_fill     = r_sh_signed & r_sh_right & r_sh[XLEN-1];
    assign w_sh_word  = r_sh_right ? ((r_sh >> r_shamt) | (w_fill ? ~(ONES >> r_shamt) : '0))
                                   : (r_sh << r_shamt);
    assign w_sh_slice = w_sh_word[IW'(int'(r_cnt) * W) +: W];
`else
    logic w_sh_ctl_unused;
    assign w_sh_ctl_unused = i_sh_right ^ i_sh_signed;
    assign w_sh_slice      = '0;
`endif

    always_comb begin
        w_lt_slice    = '0;
        w_lt_slice[0] = w_first & r_lt;
    end

    always_comb begin
        o_rd       = '0;
        o_rd_valid = 1'b0;
        if (w_load && !r_two_phase) begin
            o_rd_valid = 1'b1;
            case (r_rd_sel)
                ALU_RESULT_ADD: o_rd = w_add_sum;
                ALU_RESULT_XOR: o_rd = i_rs1 ^ i_op_b;
                ALU_RESULT_OR:  o_rd = i_rs1 | i_op_b;
                ALU_RESULT_AND: o_rd = i_rs1 & i_op_b;
                default:        o_rd = '0;
            endcase
        end else if (w_out) begin
            o_rd_valid = 1'b1;
            o_rd       = (r_rd_sel == ALU_RESULT_LT) ? w_lt_slice : w_sh_slice;
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = (w_load & w_last & ~r_two_phase) | (w_out & w_last);
    assign o_cmp  = o_done & (r_cmp_neg ^ ((r_cmp_sel == ALU_CMP_LT) ? w_lt : w_eq));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rd_sel    <= ALU_RESULT_ADD;
            r_sub       <= 1'b0;
            r_cmp_sel   <= 1'b0;
            r_cmp_neg   <= 1'b0;
            r_cmp_uns   <= 1'b0;
            r_two_phase <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_LOAD;
                        r_cnt       <= '0;
                        r_rd_sel    <= i_rd_sel;
                        r_sub       <= i_sub;
                        r_cmp_sel   <= i_cmp_sel;
                        r_cmp_neg   <= i_cmp_neg;
                        r_cmp_uns   <= i_cmp_uns;
                        r_two_phase <= (i_rd_sel == ALU_RESULT_LT) |
                                       (SHIFT_EN & (i_rd_sel == ALU_RESULT_SR));
                    end
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_eq  <= w_eq_now;
                    if (w_last) begin
                        r_lt    <= w_lt_now;
                        r_cnt   <= '0;
                        r_state <= r_two_phase ? S_OUT : S_IDLE;
                    end
                end
                S_OUT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serv_alu_wide.sv
// Scoreboard bench for serv_alu_wide: one instance each of W=1,2,4,8 on shared buses.
// Expected words account for builds with and without SERV_ALU_SHIFT_EN.
module tb_serv_alu_wide;
    import serv_alu_pkg::*;

`ifdef SERV_ALU_SHIFT_EN
    localparam bit SH_EN = 1'b1;
`else
    localparam bit SH_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] start_v;
    logic [2:0] sel;
    logic       sub, csel, neg, uns, right, sgn;
    logic [7:0] rs1_bus, opb_bus;

    logic [7:0] mon_rd    [4];
    logic       mon_valid [4];
    logic       mon_cmp   [4];
    logic       mon_busy  [4];
    logic       mon_done  [4];

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int          inst;
        logic [31:0] word;
        logic        cmp;
        longint      done_cyc;
        longint      first_cyc;
    } exp_t;
    exp_t exp_q[$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WK = 1 << g;
        logic [WK-1:0] rd;
        logic          valid, cmp, busy, done;

        serv_alu_wide #(.W(WK), .XLEN(32)) u_dut (
            .clk         (clk),
            .i_rst       (rst),
            .i_start     (start_v[g]),
            .i_rd_sel    (sel),
            .i_sub       (sub),
            .i_cmp_sel   (csel),
            .i_cmp_neg   (neg),
            .i_cmp_uns   (uns),
            .i_sh_right  (right),
            .i_sh_signed (sgn),
            .i_rs1       (rs1_bus[WK-1:0]),
            .i_op_b      (opb_bus[WK-1:0]),
            .o_rd        (rd),
            .o_rd_valid  (valid),
            .o_cmp       (cmp),
            .o_busy      (busy),
            .o_done      (done)
        );

        assign mon_rd[g]    = 8'(rd);
        assign mon_valid[g] = valid;
        assign mon_cmp[g]   = cmp;
        assign mon_busy[g]  = busy;
        assign mon_done[g]  = done;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: reassembles streamed slices and checks each completion against the queue.
    logic [31:0] acc      [4];
    int          nval     [4];
    longint      firstv   [4];
    bit          busy_chk [4];

    initial begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            acc[k] = '0; nval[k] = 0; firstv[k] = 0; busy_chk[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (busy_chk[k]) begin
                    chk($sformatf("w%0d_busy_fall", 1 << k), 32'(mon_busy[k]), 32'd0);
                    busy_chk[k] = 1'b0;
                end
                if (!mon_busy[k]) begin
                    acc[k]  = '0;
                    nval[k] = 0;
                end
                if (mon_valid[k]) begin
                    if (nval[k] == 0) firstv[k] = cyc;
                    acc[k]  = acc[k] | (32'(mon_rd[k]) << (nval[k] * (1 << k)));
                    nval[k] = nval[k] + 1;
                end
                if (mon_done[k]) begin
                    chk($sformatf("w%0d_done_expected", 1 << k), 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("w%0d_inst", 1 << k), 32'(k), 32'(e.inst));
                        chk($sformatf("w%0d_word", 1 << k), acc[k], e.word);
                        chk($sformatf("w%0d_cmp", 1 << k), 32'(mon_cmp[k]), 32'(e.cmp));
                        chk($sformatf("w%0d_done_cycle", 1 << k), 32'(cyc), 32'(e.done_cyc));
                        chk($sformatf("w%0d_first_valid", 1 << k), 32'(firstv[k]), 32'(e.first_cyc));
                        chk($sformatf("w%0d_slices", 1 << k), 32'(nval[k]), 32'(32 >> k));
                    end
                    busy_chk[k] = 1'b1;
                    acc[k]      = '0;
                    nval[k]     = 0;
                end else if (mon_cmp[k]) begin
                    chk($sformatf("w%0d_cmp_outside_done", 1 << k), 32'(mon_cmp[k]), 32'd0);
                end
            end
        end
    end

    task automatic run_op(input int k, input logic [2:0] op,
                          input logic f_sub, input logic f_csel, input logic f_neg,
                          input logic f_uns, input logic f_right, input logic f_sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ew, input logic ec,
                          input int restart_beat, input int abort_beat);
        int     nb, wk, guard;
        logic   two;
        longint c0;
        exp_t   e;
        nb  = 32 >> k;
        wk  = 1 << k;
        two = (op == ALU_RESULT_LT) || ((op == ALU_RESULT_SR) && SH_EN);
        sel = op; sub = f_sub; csel = f_csel; neg = f_neg;
        uns = f_uns; right = f_right; sgn = f_sgn;
        start_v[k] = 1'b1;
        c0 = cyc;
        if (abort_beat < 0) begin
            e.inst      = k;
            e.word      = ((op == ALU_RESULT_SR) && !SH_EN) ? 32'h0 : ew;
            e.cmp       = ec;
            e.done_cyc  = c0 + (two ? 2 * nb : nb);
            e.first_cyc = c0 + 1 + (two ? nb : 0);
            exp_q.push_back(e);
        end
        for (int beat = 0; beat < nb; beat++) begin
            tick();
            start_v[k] = (beat == restart_beat);
            sel = ~op; sub = ~f_sub; csel = ~f_csel; neg = ~f_neg;
            uns = ~f_uns; right = ~f_right; sgn = ~f_sgn;
            rs1_bus = 8'(a >> (beat * wk));
            opb_bus = 8'(b >> (beat * wk));
            if (beat == abort_beat) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk($sformatf("w%0d_abort_outputs", wk),
                    32'({mon_rd[k], mon_valid[k], mon_cmp[k], mon_busy[k], mon_done[k]}), 32'd0);
                return;
            end
        end
        tick();
        start_v[k] = 1'b0;
        rs1_bus = '0;
        opb_bus = '0;
        guard = 0;
        while (mon_busy[k] && guard < 4 * nb + 8) begin
            tick();
            guard++;
        end
        chk($sformatf("w%0d_op_terminates", wk), 32'(mon_busy[k]), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start_v = '0; sel = '0; sub = 0; csel = 0; neg = 0;
        uns = 0; right = 0; sgn = 0; rs1_bus = '0; opb_bus = '0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++)
            chk($sformatf("w%0d_reset_outputs", 1 << k),
                32'({mon_rd[k], mon_valid[k], mon_cmp[k], mon_busy[k], mon_done[k]}), 32'd0);
        rst = 1'b0;
        tick();

        //     k  op              sub csel neg uns rgt sgn  rs1           op_b          expected      cmp restart abort
        run_op(2, ALU_RESULT_ADD, 0,  0,   0,  0,  0,  0,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0,  -1, -1);
        run_op(2, ALU_RESULT_ADD, 1,  1,   0,  0,  0,  0,   32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1,  -1, -1);
        run_op(2, ALU_RESULT_ADD, 1,  1,   1,  0,  0,  0,   32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0,  -1, -1);
        run_op(1, ALU_RESULT_SR,  0,  0,   0,  0,  1,  1,   32'h80000010, 32'h00000004, 32'hF8000001, 0,  -1, -1);
        run_op(3, ALU_RESULT_LT,  0,  1,   0,  1,  0,  0,   32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1,  -1, -1);
        run_op(3, ALU_RESULT_LT,  0,  1,   0,  0,  0,  0,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0,  -1, -1);
        run_op(1, ALU_RESULT_LT,  0,  1,   0,  0,  0,  0,   32'hFFFFFFFB, 32'h00000003, 32'h00000001, 1,  -1, -1);
        run_op(0, ALU_RESULT_ADD, 0,  0,   0,  0,  0,  0,   32'h12345678, 32'h11111111, 32'h23456789, 0,  10, -1);
        run_op(2, ALU_RESULT_XOR, 0,  0,   0,  0,  0,  0,   32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1,  -1, -1);
        run_op(1, ALU_RESULT_OR,  0,  0,   0,  0,  0,  0,   32'hF0F00000, 32'h0F0F00FF, 32'hFFFF00FF, 0,  -1, -1);
        run_op(3, ALU_RESULT_AND, 0,  0,   1,  0,  0,  0,   32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1,  -1, -1);
        run_op(2, ALU_RESULT_SR,  0,  0,   0,  0,  0,  1,   32'h00000001, 32'h0000001F, 32'h80000000, 0,  -1, -1);
        run_op(0, ALU_RESULT_SR,  0,  0,   0,  0,  0,  0,   32'h00000001, 32'hFFFFFFE3, 32'h00000008, 0,  -1, -1);
        run_op(3, ALU_RESULT_SR,  0,  0,   0,  0,  1,  0,   32'h80000000, 32'h00000001, 32'h40000000, 0,  -1, -1);
        run_op(2, ALU_RESULT_SR,  0,  0,   0,  0,  1,  0,   32'hF0000000, 32'h00000004, 32'h0F000000, 0,  -1,  3);
        run_op(2, ALU_RESULT_ADD, 0,  0,   0,  0,  0,  0,   32'h00000003, 32'h00000004, 32'h00000007, 0,  -1, -1);

        repeat (4) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
